ib_dnu_lut_loader: RTL

- Write-side driver for the symmetric IB-DNU LUT RAM (sym_dn_lut_out) inside the dnu_f* datapaths.
- On each iteration update, it takes a stream of LUT words from the upstream IB-LUT source. It writes one frame region of the RAM page by page through the page_addr_ram / ram_write_data_1 / ib_ram_we interface.
- It runs in the write-clock domain. The selected multi-frame offset goes in the page-address MSBs, so the read side can keep decoding the other frame.

---
 rtl/ib_dnu_lut_loader_pkg.sv | 19 +
 rtl/ib_dnu_lut_loader.sv | 102 ++++++++++
 2 files changed

// File: rtl/ib_dnu_lut_loader_pkg.sv
// Shared definitions for the IB-DNU LUT write-side loader.
// State encodings and frame/page geometry helpers.
package ib_dnu_lut_loader_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   // Width of the multi-frame offset field.
   function automatic int frame_w(input int frames);
      return $clog2(frames);
   endfunction

   // Width of the per-frame page counter.
   function automatic int page_w(input int entry_addr, input int frames);
      return entry_addr - $clog2(frames);
   endfunction

endpackage

// File: rtl/ib_dnu_lut_loader.sv
// Write-side loader for the symmetric IB-DNU LUT RAM.
// Streams one frame region page by page into the RAM write port.
module ib_dnu_lut_loader
   import ib_dnu_lut_loader_pkg::*;
#(
   parameter  int ENTRY_ADDR      = 5,
   parameter  int MULTI_FRAME_NUM = 2,
   parameter  int BANK_NUM        = 2,
   parameter  int LUT_PORT_SIZE   = 1,
   localparam int FW = frame_w(MULTI_FRAME_NUM),
   localparam int PW = page_w(ENTRY_ADDR, MULTI_FRAME_NUM),
   localparam int DW = LUT_PORT_SIZE * BANK_NUM
) (
   input  logic                  write_clk,
   input  logic                  rstn,
   input  logic                  update_req,
   input  logic [FW-1:0]         update_frame,
   input  logic [DW-1:0]         lut_data_in,
   input  logic                  lut_data_valid,
   output logic                  lut_data_ready,
   output logic [ENTRY_ADDR-1:0] page_addr_ram,
   output logic [DW-1:0]         ram_write_data_1,
   output logic                  ib_ram_we,
   output logic                  busy,
   output logic                  update_done
);

   logic [1:0]            r_state;
   logic [PW-1:0]         r_cnt;
   logic [FW-1:0]         r_frame;
   logic [ENTRY_ADDR-1:0] r_addr;
   logic [DW-1:0]         r_data;
   logic                  r_we;

   logic w_ready;
   logic w_accept;
   logic w_last;

   assign w_ready  = (r_state == S_LOAD);
   assign w_accept = w_ready & lut_data_valid;
   assign w_last   = &r_cnt;

   // State sequencing: IDLE -> LOAD until last page -> one FLUSH cycle.
   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (update_req) r_state <= S_LOAD;
            end
            S_LOAD: begin
               if (w_accept && w_last) r_state <= S_FLUSH;
            end
            S_FLUSH: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Frame latch and page counter; the counter wraps inside the page field.
   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_frame <= '0;
         r_cnt   <= '0;
      end else if (r_state == S_IDLE) begin
         if (update_req) begin
            r_frame <= update_frame;
            r_cnt   <= '0;
         end
      end else if (w_accept) begin
         r_cnt <= r_cnt + PW'(1);
      end
   end

   // Write port register: address/data hold across stalls, we pulses per beat.
   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_addr <= '0;
         r_data <= '0;
         r_we   <= 1'b0;
      end else begin
         r_we <= w_accept;
         if (w_accept) begin
            r_addr <= {r_frame, r_cnt};
            r_data <= lut_data_in;
         end
      end
   end

   assign lut_data_ready   = w_ready;
   assign page_addr_ram    = r_addr;
   assign ram_write_data_1 = r_data;
   assign ib_ram_we        = r_we;
   assign busy             = (r_state != S_IDLE);
   assign update_done      = (r_state == S_FLUSH);

endmodule
